// File: rtl/dmem_responder.sv
// Word-addressed data memory responder for the CPU MEM stage: one request at a
// time, fixed wait states, byte-enabled stores, misalignment/range error flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready. A side
    // raising valid holds it and its payload until the transfer edge.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  access_err;
    logic                  mem_we;

    assign word_idx   = addr_q[ADDR_WIDTH+1:2];
    assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH+2] != '0);
    assign mem_we     = (state_q == ST_ACCESS) && write_q && !access_err;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_err_d   = access_err;
                resp_rdata_d = (access_err || write_q) ? 32'h0 : mem_q[word_idx];
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    // Storage is deliberately not reset; an asynchronous reset leaves state_q
    // outside ACCESS, so an in-flight store never reaches this port.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scoreboard-checked randomized traffic against a word-array
// reference model (WAIT_CYCLES=2), plus a zero-wait-state instance for timing.
module tb_dmem_responder;
    localparam int AW = 10;
    localparam int W  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, resp_ready0 = 1'b1;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [3:0]  req_be0 = '0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
    logic [1:0]  dbg_state0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rr = 1'b0;

    // expected response: {check_rdata, err, rdata}
    logic [33:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] ref_mem [int];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_ready(resp_ready), .dbg_state(dbg_state)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .resp_ready(resp_ready0), .dbg_state(dbg_state0)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: capacity is 4*2^AW bytes, word aligned; stores merge enabled bytes.
    function automatic logic [33:0] model(input logic wr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
        int          idx;
        logic [31:0] w;
        if ((addr % 4) != 0 || addr >= 32'(4 << AW)) return {1'b1, 1'b1, 32'h0};
        idx = int'(addr / 4);
        if (wr) begin
            if (ref_mem.exists(idx) || be == 4'hF) begin
                w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                ref_mem[idx] = w;
            end
            return {1'b1, 1'b0, 32'h0};
        end
        if (ref_mem.exists(idx)) return {1'b1, 1'b0, ref_mem[idx]};
        return {1'b0, 1'b0, 32'h0};
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        logic [33:0] e;
        int n;
        e = model(wr, addr, wdata, be);
        tick();
        req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin tick(); n++; end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
        req_be = 4'($urandom_range(0, 15));
        chk("req_ready_drop", 32'(req_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_v = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    always @(negedge clock) begin
        logic [33:0] e;
        int a;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (resp_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("resp_err", 32'(resp_err), 32'(e[32]));
                    if (e[33]) chk("resp_rdata", resp_rdata, e[31:0]);
                    chk("resp_latency", 32'(cyc), 32'(a + W + 1));
                end
                held_rdata = resp_rdata;
                held_err   = resp_err;
            end else if (resp_valid && prev_v) begin
                chk("hold_rdata", resp_rdata, held_rdata);
                chk("hold_err", 32'(resp_err), 32'(held_err));
            end
            if (resp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
            prev_v = resp_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int last, nacc, n;
        logic [31:0] d0;

        // reset
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        #1 chk("rel_req_ready_pre", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("rel_req_ready_post", 32'(req_ready), 32'd1);

        // full-word store/load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        // byte enables
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        // errors and boundary
        do_req(1'b1, 32'h0, 32'h12345678, 4'hF);
        do_req(1'b0, 32'h22, 32'h0, 4'h0);
        do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
        do_req(1'b1, 32'h0FFC, 32'h0BADC0DE, 4'hF);
        do_req(1'b0, 32'h0FFC, 32'h0, 4'h0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        drain();

        // backpressure
        resp_ready = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        n = 0;
        while (!resp_valid && n < 50) begin tick(); n++; end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF; req_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h11BB33DD);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        drain();

        // reset while a store waits
        do_req(1'b1, 32'h30, 32'h0, 4'hF);
        drain();
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        chk("mid_rst_err", 32'(resp_err), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        tick();
        reset = 1'b0;
        do_req(1'b0, 32'h30, 32'h0, 4'h0);
        drain();

        // randomized traffic under random backpressure
        for (int i = 0; i < 8; i++) do_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF);
        rand_rr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h1000 + ($urandom & 32'h00FF_FFFC);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_rr = 1'b0;
        resp_ready = 1'b1;
        drain();

        // zero wait states
        d0 = $urandom;
        tick();
        req_write0 = 1'b1; req_addr0 = 32'h40; req_wdata0 = d0; req_be0 = 4'hF; req_valid0 = 1'b1;
        n = 0;
        while (!req_ready0 && n < 20) begin tick(); n++; end
        tick();
        req_valid0 = 1'b0;
        chk("w0_valid_early", 32'(resp_valid0), 32'd0);
        tick();
        chk("w0_valid_latency", 32'(resp_valid0), 32'd1);
        chk("w0_store_err", 32'(resp_err0), 32'd0);
        tick();
        chk("w0_valid_clear", 32'(resp_valid0), 32'd0);
        chk("w0_ready_back", 32'(req_ready0), 32'd1);
        req_write0 = 1'b0; req_addr0 = 32'h40; req_valid0 = 1'b1;
        last = -1; nacc = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready0) begin
                if (last >= 0) chk("w0_spacing", 32'(cyc + 1 - last), 32'd3);
                last = cyc + 1;
                nacc++;
            end
            if (resp_valid0) begin
                chk("w0_rdata", resp_rdata0, d0);
                chk("w0_resp_lat", 32'(cyc), 32'(last + 1));
            end
            tick();
        end
        req_valid0 = 1'b0;
        chk("w0_acc_count", 32'(nacc >= 4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
